// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch PC generator.
package pc_gen_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int unsigned STEP_DEF = 4;
  localparam int unsigned STEP_LSB = $clog2(STEP_DEF);

  // Clear the low lsb bits of an address (align down to 2^lsb).
  function automatic logic [63:0] align_down(input logic [63:0] addr, input int unsigned lsb);
    logic [63:0] mask;
    mask = ~((64'd1 << lsb) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push on a full stack overwrites the
// oldest entry; a pop on an empty stack is ignored. A push and pop in the
// same cycle replaces the top entry (depth unchanged).
module pc_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_addr_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx, ptr_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_eff;

  assign top_idx = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign pop_eff = pop_i & (cnt_q != '0);
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[top_idx];

  // Pointer/count update for push, pop and combined push+pop.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i && !pop_eff) begin
      ptr_d = ptr_inc;
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_eff && !push_i) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Stack bookkeeping registers; reset empties the stack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage: combined push+pop rewrites the current top.
  always_ff @(posedge clk) begin
    if (push_i) begin
      if (pop_eff) mem_q[top_idx] <= push_addr_i;
      else         mem_q[ptr_q]   <= push_addr_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT control, valid/ready fetch
// handshake, prioritised next-pc selection and redirect alignment flag.
// Optional return-address stack enabled with macro PC_GEN_RAS_EN.
//
// state | meaning
// BOOT  | one cycle after reset, no fetch, redirects ignored
// RUN   | pc_valid asserted, pc advances on accept
// HALT  | fetch stopped, pc held until resume or trap
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
`ifdef PC_GEN_RAS_EN
  parameter int unsigned     RAS_DEPTH    = 4,
`endif
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int unsigned     STEP         = STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic            halt_req_i,
  input  logic            pc_ready_i,
`ifdef PC_GEN_RAS_EN
  input  logic            ras_push_i,
  input  logic [XLEN-1:0] ras_push_addr_i,
  input  logic            ras_pop_i,
  output logic            ras_empty_o,
`endif
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            halted_o,
  output logic            misalign_o
);

  localparam int unsigned LSB = $clog2(STEP);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            live, fire;
  logic [XLEN-1:0] redir_target;

  assign live         = (state_q != ST_BOOT);
  assign pc_valid_o   = (state_q == ST_RUN);
  assign halted_o     = (state_q == ST_HALT);
  assign fire         = pc_valid_o & pc_ready_i & ~stall_i;
  assign redir_target = XLEN'(align_down(64'(redirect_pc_i), LSB));
  assign pc_o         = pc_q;
  assign misalign_o   = misalign_q;

`ifdef PC_GEN_RAS_EN
  logic            ras_take;
  logic [XLEN-1:0] ras_top;

  // A predicted return only wins when no trap or branch redirect is present.
  assign ras_take = live & ~trap_valid_i & ~redirect_valid_i & ras_pop_i & ~ras_empty_o;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push_i),
    .push_addr_i (ras_push_addr_i),
    .pop_i       (ras_take),
    .top_o       (ras_top),
    .empty_o     (ras_empty_o)
  );
`endif

  // Next-state logic: HALT only entered when the current request was not accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt_req_i && !fire) state_d = ST_HALT;
      ST_HALT: if (!halt_req_i || trap_valid_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // Next-pc priority: trap, redirect, return stack, sequential, hold.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = live & redirect_valid_i & (redirect_pc_i[LSB-1:0] != '0);
    if (live && trap_valid_i)          pc_d = TRAP_VECTOR;
    else if (live && redirect_valid_i) pc_d = redir_target;
`ifdef PC_GEN_RAS_EN
    else if (ras_take)                 pc_d = ras_top;
`endif
    else if (fire)                     pc_d = pc_q + XLEN'(STEP);
  end

  // State, pc and misalign registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_valid, trap_valid, halt_req, pc_ready;
  logic [31:0] redirect_pc;
  logic        pc_valid, halted, misalign;
  logic [31:0] pc;
`ifdef PC_GEN_RAS_EN
  logic        ras_push, ras_pop, ras_empty;
  logic [31:0] ras_push_addr;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic exp_empty = 1'b1;

  typedef struct {
    int          cyc;
    string       nm;
    logic        v;
    logic [31:0] p;
    logic        h;
    logic        m;
    logic        e;
  } exp_t;

  exp_t q[$];

  pc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .trap_valid_i     (trap_valid),
    .halt_req_i       (halt_req),
    .pc_ready_i       (pc_ready),
`ifdef PC_GEN_RAS_EN
    .ras_push_i       (ras_push),
    .ras_push_addr_i  (ras_push_addr),
    .ras_pop_i        (ras_pop),
    .ras_empty_o      (ras_empty),
`endif
    .pc_valid_o       (pc_valid),
    .pc_o             (pc),
    .halted_o         (halted),
    .misalign_o       (misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h (cycle %0d)", nm, fld, act, exp, cyc);
  endtask

  // Monitor: compare every expectation due at or before the current cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        x = q.pop_front();
        chk(x.nm, "pc_valid", 32'(pc_valid), 32'(x.v));
        chk(x.nm, "pc",       pc,            x.p);
        chk(x.nm, "halted",   32'(halted),   32'(x.h));
        chk(x.nm, "misalign", 32'(misalign), 32'(x.m));
`ifdef PC_GEN_RAS_EN
        chk(x.nm, "ras_empty", 32'(ras_empty), 32'(x.e));
`endif
      end
    end
  end

  // Queue the outputs expected after the next edge, then advance one cycle.
  task automatic tick(input string nm, input logic v, input logic [31:0] p, input logic h, input logic m);
    exp_t x;
    x.cyc = cyc + 1;
    x.nm  = nm;
    x.v   = v;
    x.p   = p;
    x.h   = h;
    x.m   = m;
    x.e   = exp_empty;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    halt_req = 1'b0; pc_ready = 1'b0; redirect_pc = '0;
`ifdef PC_GEN_RAS_EN
    ras_push = 1'b0; ras_pop = 1'b0; ras_push_addr = '0;
`endif
    @(posedge clk); #1;

    // reset release: BOOT then RUN at RESET_VECTOR
    tick("rst_boot", 0, 32'h0, 0, 0);
    rst = 1'b1;
    tick("rst_run", 1, 32'h0, 0, 0);

    // streaming with a one-cycle stall
    pc_ready = 1'b1;
    tick("stream4", 1, 32'h4, 0, 0);
    tick("stream8", 1, 32'h8, 0, 0);
    stall = 1'b1;
    tick("stall_hold", 1, 32'h8, 0, 0);
    stall = 1'b0;
    tick("streamC", 1, 32'hC, 0, 0);

    // backpressure then redirect abandons the pending request
    pc_ready = 1'b0;
    tick("bp_hold", 1, 32'hC, 0, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick("bp_redir", 1, 32'h40, 0, 0);
    redirect_valid = 1'b0;
    tick("redir_hold", 1, 32'h40, 0, 0);

    // trap beats misaligned redirect; misalign still flagged
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick("trap_prio", 1, 32'h100, 0, 1);
    trap_valid = 1'b0; redirect_valid = 1'b0;
    tick("mis_clear", 1, 32'h100, 0, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick("redir_align", 1, 32'h40, 0, 1);

    // wrap at top of address space
    redirect_pc = 32'hFFFF_FFFC;
    tick("to_top", 1, 32'hFFFF_FFFC, 0, 0);
    redirect_valid = 1'b0; pc_ready = 1'b1;
    tick("wrap", 1, 32'h0, 0, 0);

    // halt, hold, trap exit
    halt_req = 1'b1; pc_ready = 1'b0;
    tick("halt", 0, 32'h0, 1, 0);
    pc_ready = 1'b1;
    tick("halt_hold", 0, 32'h0, 1, 0);
    trap_valid = 1'b1;
    tick("trap_halt", 1, 32'h100, 0, 0);
    trap_valid = 1'b0; halt_req = 1'b0;
    tick("resume", 1, 32'h104, 0, 0);
    halt_req = 1'b1;
    tick("halt_fire", 1, 32'h108, 0, 0);
    pc_ready = 1'b0;
    tick("halt2", 0, 32'h108, 1, 0);
    halt_req = 1'b0;
    tick("unhalt", 1, 32'h108, 0, 0);

    // mid-run reset, redirect ignored during BOOT
    rst = 1'b0;
    tick("rst_mid", 0, 32'h0, 0, 0);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h82;
    tick("boot_ign", 1, 32'h0, 0, 0);
    redirect_valid = 1'b0;

`ifdef PC_GEN_RAS_EN
    // five pushes into a four-deep stack, then five pops
    ras_push = 1'b1;
    exp_empty = 1'b0;
    ras_push_addr = 32'h10; tick("push10", 1, 32'h0, 0, 0);
    ras_push_addr = 32'h20; tick("push20", 1, 32'h0, 0, 0);
    ras_push_addr = 32'h30; tick("push30", 1, 32'h0, 0, 0);
    ras_push_addr = 32'h40; tick("push40", 1, 32'h0, 0, 0);
    ras_push_addr = 32'h50; tick("push50", 1, 32'h0, 0, 0);
    ras_push = 1'b0; ras_pop = 1'b1;
    tick("pop50", 1, 32'h50, 0, 0);
    tick("pop40", 1, 32'h40, 0, 0);
    tick("pop30", 1, 32'h30, 0, 0);
    exp_empty = 1'b1;
    tick("pop20", 1, 32'h20, 0, 0);
    tick("pop_empty", 1, 32'h20, 0, 0);
    ras_pop = 1'b0;
`endif

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
      n_checks += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
